dcom_uart_fifo: RTL and testbench
=================================

Name: dcom_uart_fifo

Overview:
Buffered APB front-end for the DCOM UART's byte-level com port. It holds a TX FIFO that drains into the UART's Write/DataIn/THEmpty handshake and an RX FIFO that fills from its DataReady/DataOut/Read handshake. It sits between the APB bus and the UART, so software moves bursts of bytes without polling per character. It also raises a level interrupt on RX-data-available or TX-empty.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (default 16 entries per FIFO)
TXDATA_ADDR, 6'h00, PADDR[5:0] of TX data register (write-only)
RXDATA_ADDR, 6'h04, PADDR[5:0] of RX data register (read-only)
FSTAT_ADDR, 6'h08, PADDR[5:0] of FIFO status/control register

Ports:
PCLK  in  1  clock; single clock domain
PRST_N  in  1  reset, asynchronous assert, active-low
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write
PADDR  in  32  APB address; only [5:0] decoded
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
IRQ  out  1  registered level interrupt
UartWrite  out  1  to UART Write; one-cycle pulse
UartDataIn  out  8  to UART DataIn; valid while UartWrite=1
UartTHEmpty  in  1  from UART THEmpty
UartDataReady  in  1  from UART DataReady
UartDataOut  in  8  from UART DataOut
UartRead  out  1  to UART Read; one-cycle pulse

Behaviour:
- Reset values: PRDATA=0, IRQ=0, UartWrite=0, UartRead=0, UartDataIn=0. Both FIFOs are empty. TxOvf=0, RxIrqEn=0, TxIrqEn=0.
- FIFOs: pointers are DEPTH_LOG2 bits and wrap mod 2^DEPTH_LOG2. Counts are DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2. A push and a pop in the same cycle leave the count unchanged. A flush in the same cycle as a push or pop wins: count=0 and pointers=0.
- APB write, TXDATA_ADDR (PSEL&PENABLE&PWRITE): push PWDATA[7:0].
  - If the TX FIFO is full, drop the byte and set TxOvf (sticky).
  - A push into a full FIFO is dropped even if a pop occurs in the same cycle.
- TX FSM, states TX_IDLE and TX_HOLD:
  - TX_IDLE: if the FIFO is not empty and UartTHEmpty=1, register UartWrite=1 and UartDataIn=head for the next cycle, pop, and go to TX_HOLD.
  - TX_HOLD: UartWrite=1 for exactly this cycle. Return to TX_IDLE unconditionally; the UART's THEmpty is already low in the following cycle.
  - A TX flush does not recall a byte already pulsed into the UART.
- RX FSM, states RX_IDLE and RX_ACK:
  - RX_IDLE: if UartDataReady=1 and the RX FIFO is not full, push UartDataOut, register UartRead=1 for the next cycle, and go to RX_ACK.
  - RX_ACK: UartRead=1 for exactly this cycle. Return to RX_IDLE without sampling DataReady in this cycle (the UART clears it at the end of this cycle).
  - If the RX FIFO is full, no read is issued and the byte stays in the UART (back-pressure).
  - Peak throughput: one byte per 2 cycles in each direction.
- APB read: PRDATA is combinational when PSEL&~PWRITE.
  - RXDATA_ADDR: {23'b0, nonempty, head[7:0]}; when empty, all zeros.
  - The pop happens in the access phase (PSEL&PENABLE&~PWRITE) and only if nonempty.
  - An RX FIFO pop and push in the same cycle are both honoured.
- FSTAT_ADDR read layout:
  - [7:0] tx count, zero-extended
  - [15:8] rx count
  - [16] tx empty, [17] tx full
  - [18] rx empty, [19] rx full
  - [20] TxOvf
  - [21] TX FSM busy (not TX_IDLE)
  - [24] RxIrqEn, [25] TxIrqEn
  - all other bits 0
- FSTAT_ADDR write fields:
  - [20] write-1-clears TxOvf; if a set and a clear coincide, set wins.
  - [24] and [25] load the IRQ enables.
  - [28]=1 flushes TX and [29]=1 flushes RX, one-shot, not stored.
- Undecoded PADDR[5:0]: reads return 0 and writes are ignored. The UART's own registers at 0x20/0x30 do not overlap.
- IRQ: registered, IRQ <= (RxIrqEn & rx nonempty) | (TxIrqEn & tx empty & TX_IDLE). This gives 1 cycle of latency from the status change.
- Reset mid-transfer: all state is cleared asynchronously and any pending UartWrite/UartRead pulse is cancelled.

Test Plan:
- Reset, then read FSTAT -> 0x0005_0000 (tx empty, rx empty); IRQ=0; UartWrite=UartRead=0.
- Hold UartTHEmpty=1 and write 0x41, 0x42, 0x43 to TXDATA -> three UartWrite pulses carrying 0x41, 0x42, 0x43 in order, each followed by at least 1 idle cycle. Then hold THEmpty=0 -> no further pulses, FIFO count frozen.
- Hold THEmpty=0 and write 17 bytes -> tx count=16, FSTAT[17]=1, TxOvf=1; write FSTAT bit20=1 -> TxOvf=0, count still 16.
- Drive DataReady=1 with DataOut=0x5A -> UartRead pulses in the next cycle; rx count=1; RXDATA read returns 0x15A and count becomes 0. A second read returns 0x000.
- Fill RX to 16 with DataReady held high -> no UartRead while full; one RXDATA pop -> exactly one UartRead follows and count returns to 16.
- Set RxIrqEn, push one RX byte -> IRQ=1 one cycle after the push. Write FSTAT bit29 with bit24 set -> rx count=0 and IRQ falls the next cycle. Assert PRST_N=0 during a TX_HOLD cycle -> UartWrite drops immediately.

Source files
------------

// File: rtl/dcom_uart_fifo.sv
// dcom_uart_fifo: buffered APB front-end for the DCOM UART byte-level com port.
// A TX FIFO drains into the UART Write/DataIn/THEmpty handshake and an RX FIFO
// fills from the DataReady/DataOut/Read handshake. A level IRQ flags RX data or TX empty.
// Ports:
//   PCLK, PRST_N                      clock, async active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request (only PADDR[5:0] decoded)
//   PRDATA                            APB read data, combinational while PSEL & ~PWRITE
//   IRQ                               registered level interrupt
//   UartWrite/UartDataIn/UartTHEmpty  TX handshake to the UART
//   UartDataReady/UartDataOut/UartRead RX handshake from the UART
module dcom_uart_fifo #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter logic [5:0]  TXDATA_ADDR = 6'h00,
  parameter logic [5:0]  RXDATA_ADDR = 6'h04,
  parameter logic [5:0]  FSTAT_ADDR  = 6'h08
) (
  input  logic        PCLK,
  input  logic        PRST_N,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        IRQ,
  output logic        UartWrite,
  output logic [7:0]  UartDataIn,
  input  logic        UartTHEmpty,
  input  logic        UartDataReady,
  input  logic [7:0]  UartDataOut,
  output logic        UartRead
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam int unsigned PtrW  = DEPTH_LOG2;

  typedef enum logic [0:0] {TxIdle, TxHold} tx_state_e;
  typedef enum logic [0:0] {RxIdle, RxAck}  rx_state_e;

  logic [7:0]      r_tx_mem [Depth];
  logic [7:0]      r_rx_mem [Depth];
  logic [PtrW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [CntW-1:0] r_tx_cnt, r_rx_cnt, w_tx_cnt_d, w_rx_cnt_d;
  tx_state_e       r_tx_state, w_tx_state_d;
  rx_state_e       r_rx_state, w_rx_state_d;
  logic            r_tx_ovf, r_rx_irq_en, r_tx_irq_en, r_irq;
  logic [7:0]      r_uart_data_in;

  logic       w_wr, w_rd_acc;
  logic [5:0] w_addr;
  logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic       w_tx_push, w_tx_pop, w_tx_flush, w_rx_push, w_rx_pop, w_rx_flush;
  logic       w_ovf_set, w_ovf_clr, w_fstat_wr;
  logic [7:0] w_tx_head, w_rx_head;
  logic       w_unused;

  assign w_addr     = PADDR[5:0];
  assign w_wr       = PSEL & PENABLE & PWRITE;
  assign w_rd_acc   = PSEL & PENABLE & ~PWRITE;
  assign w_fstat_wr = w_wr & (w_addr == FSTAT_ADDR);

  assign w_tx_full  = (r_tx_cnt == CntW'(Depth));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == CntW'(Depth));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_tx_head  = r_tx_mem[r_tx_rptr];
  assign w_rx_head  = r_rx_mem[r_rx_rptr];

  assign w_tx_flush = w_fstat_wr & PWDATA[28];
  assign w_rx_flush = w_fstat_wr & PWDATA[29];
  // A push into a full TX FIFO is dropped even when a pop happens alongside it.
  assign w_tx_push  = w_wr & (w_addr == TXDATA_ADDR) & ~w_tx_full;
  assign w_ovf_set  = w_wr & (w_addr == TXDATA_ADDR) & w_tx_full;
  assign w_ovf_clr  = w_fstat_wr & PWDATA[20];
  assign w_rx_pop   = w_rd_acc & (w_addr == RXDATA_ADDR) & ~w_rx_empty;

  assign w_unused = ^{PADDR[31:6], PWDATA[31:30], PWDATA[27:26], PWDATA[23:21], PWDATA[19:8]};

  // TX FSM next-state; a flush in the same cycle suppresses the launch.
  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_pop     = 1'b0;
    case (r_tx_state)
      TxIdle: begin
        if (!w_tx_empty && UartTHEmpty && !w_tx_flush) begin
          w_tx_pop     = 1'b1;
          w_tx_state_d = TxHold;
        end
      end
      TxHold:  w_tx_state_d = TxIdle;
      default: w_tx_state_d = TxIdle;
    endcase
  end

  // RX FSM next-state; RxAck never samples DataReady (UART clears it at end of that cycle).
  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_push    = 1'b0;
    case (r_rx_state)
      RxIdle: begin
        if (UartDataReady && !w_rx_full && !w_rx_flush) begin
          w_rx_push    = 1'b1;
          w_rx_state_d = RxAck;
        end
      end
      RxAck:   w_rx_state_d = RxIdle;
      default: w_rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    w_tx_cnt_d = r_tx_cnt;
    if (w_tx_flush)               w_tx_cnt_d = '0;
    else if (w_tx_push && !w_tx_pop) w_tx_cnt_d = r_tx_cnt + CntW'(1);
    else if (w_tx_pop && !w_tx_push) w_tx_cnt_d = r_tx_cnt - CntW'(1);
  end

  always_comb begin
    w_rx_cnt_d = r_rx_cnt;
    if (w_rx_flush)               w_rx_cnt_d = '0;
    else if (w_rx_push && !w_rx_pop) w_rx_cnt_d = r_rx_cnt + CntW'(1);
    else if (w_rx_pop && !w_rx_push) w_rx_cnt_d = r_rx_cnt - CntW'(1);
  end

  // Storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge PCLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= PWDATA[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= UartDataOut;
  end

  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      r_tx_wptr      <= '0;
      r_tx_rptr      <= '0;
      r_rx_wptr      <= '0;
      r_rx_rptr      <= '0;
      r_tx_cnt       <= '0;
      r_rx_cnt       <= '0;
      r_tx_state     <= TxIdle;
      r_rx_state     <= RxIdle;
      r_tx_ovf       <= 1'b0;
      r_rx_irq_en    <= 1'b0;
      r_tx_irq_en    <= 1'b0;
      r_irq          <= 1'b0;
      r_uart_data_in <= 8'h00;
    end else begin
      r_tx_state <= w_tx_state_d;
      r_rx_state <= w_rx_state_d;
      r_tx_cnt   <= w_tx_cnt_d;
      r_rx_cnt   <= w_rx_cnt_d;
      if (w_tx_flush) begin
        r_tx_wptr <= '0;
        r_tx_rptr <= '0;
      end else begin
        if (w_tx_push) r_tx_wptr <= r_tx_wptr + PtrW'(1);
        if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PtrW'(1);
      end
      if (w_rx_flush) begin
        r_rx_wptr <= '0;
        r_rx_rptr <= '0;
      end else begin
        if (w_rx_push) r_rx_wptr <= r_rx_wptr + PtrW'(1);
        if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PtrW'(1);
      end
      if (w_tx_pop) r_uart_data_in <= w_tx_head;
      // Set wins over a coincident write-1-clear.
      if (w_ovf_set)      r_tx_ovf <= 1'b1;
      else if (w_ovf_clr) r_tx_ovf <= 1'b0;
      if (w_fstat_wr) begin
        r_rx_irq_en <= PWDATA[24];
        r_tx_irq_en <= PWDATA[25];
      end
      r_irq <= (r_rx_irq_en & ~w_rx_empty) | (r_tx_irq_en & w_tx_empty & (r_tx_state == TxIdle));
    end
  end

  assign UartWrite  = (r_tx_state == TxHold);
  assign UartRead   = (r_rx_state == RxAck);
  assign UartDataIn = r_uart_data_in;
  assign IRQ        = r_irq;

  always_comb begin
    PRDATA = 32'h0;
    if (PSEL && !PWRITE) begin
      if (w_addr == RXDATA_ADDR) begin
        PRDATA = {23'b0, ~w_rx_empty, (w_rx_empty ? 8'h00 : w_rx_head)};
      end else if (w_addr == FSTAT_ADDR) begin
        PRDATA[7:0]  = 8'(r_tx_cnt);
        PRDATA[15:8] = 8'(r_rx_cnt);
        PRDATA[16]   = w_tx_empty;
        PRDATA[17]   = w_tx_full;
        PRDATA[18]   = w_rx_empty;
        PRDATA[19]   = w_rx_full;
        PRDATA[20]   = r_tx_ovf;
        PRDATA[21]   = (r_tx_state != TxIdle);
        PRDATA[24]   = r_rx_irq_en;
        PRDATA[25]   = r_tx_irq_en;
      end
    end
  end

endmodule

// File: tb/tb_dcom_uart_fifo.sv
// Directed self-checking bench for dcom_uart_fifo.
module tb_dcom_uart_fifo;

  logic        PCLK = 1'b0;
  logic        PRST_N = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = 32'h0, PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        IRQ, UartWrite, UartRead;
  logic [7:0]  UartDataIn;
  logic        UartTHEmpty = 1'b0, UartDataReady = 1'b0;
  logic [7:0]  UartDataOut = 8'h00;

  int checks = 0;
  int failures = 0;

  // Pulse monitor
  int         tx_n = 0, rd_n = 0, b2b = 0;
  logic       prev_w = 1'b0;
  logic [7:0] tx_log [16];

  dcom_uart_fifo dut (
    .PCLK(PCLK), .PRST_N(PRST_N), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .IRQ(IRQ),
    .UartWrite(UartWrite), .UartDataIn(UartDataIn), .UartTHEmpty(UartTHEmpty),
    .UartDataReady(UartDataReady), .UartDataOut(UartDataOut), .UartRead(UartRead)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (UartWrite) begin
      tx_log[tx_n[3:0]] <= UartDataIn;
      tx_n <= tx_n + 1;
      if (prev_w) b2b <= b2b + 1;
    end
    prev_w <= UartWrite;
    if (UartRead) rd_n <= rd_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {26'h0, a}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {26'h0, a};
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  logic [31:0] rd;
  int          base;
  logic        found;

  initial begin
    // Reset
    repeat (3) @(posedge PCLK);
    #1 PRST_N = 1'b1;
    @(negedge PCLK);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    check("rst_uartwrite", {31'h0, UartWrite}, 32'h0);
    check("rst_uartread", {31'h0, UartRead}, 32'h0);
    check("rst_datain", {24'h0, UartDataIn}, 32'h0);
    apb_read(6'h08, rd);
    check("rst_fstat", rd, 32'h0005_0000);

    // TX drain of three bytes
    UartTHEmpty = 1'b1;
    apb_write(6'h00, 32'h41);
    apb_write(6'h00, 32'h42);
    apb_write(6'h00, 32'h43);
    idle(10);
    check("tx3_pulses", tx_n, 3);
    check("tx3_byte0", {24'h0, tx_log[0]}, 32'h41);
    check("tx3_byte1", {24'h0, tx_log[1]}, 32'h42);
    check("tx3_byte2", {24'h0, tx_log[2]}, 32'h43);
    check("tx3_gap", b2b, 0);

    // TX overflow with THEmpty low
    UartTHEmpty = 1'b0;
    idle(2);
    for (int i = 0; i < 17; i++) apb_write(6'h00, 32'h60 + i);
    idle(4);
    check("txfull_nopulse", tx_n, 3);
    apb_read(6'h08, rd);
    check("txfull_fstat", rd, 32'h0016_0010);
    apb_write(6'h08, 32'h0010_0000);
    apb_read(6'h08, rd);
    check("txovf_clear", rd, 32'h0006_0010);
    apb_write(6'h08, 32'h1000_0000);
    apb_read(6'h08, rd);
    check("tx_flush", rd, 32'h0005_0000);

    // Single RX byte
    UartDataOut = 8'h5A;
    UartDataReady = 1'b1;
    @(negedge PCLK);
    check("rx_read_not_yet", {31'h0, UartRead}, 32'h0);
    @(posedge PCLK); #1;
    UartDataReady = 1'b0;
    @(negedge PCLK);
    check("rx_read_pulse", {31'h0, UartRead}, 32'h1);
    @(negedge PCLK);
    check("rx_read_one_cycle", {31'h0, UartRead}, 32'h0);
    apb_read(6'h08, rd);
    check("rx_cnt1", rd, 32'h0001_0100);
    apb_read(6'h04, rd);
    check("rx_data", rd, 32'h0000_015A);
    apb_read(6'h04, rd);
    check("rx_empty_read", rd, 32'h0000_0000);

    // RX fill to 16 with back-pressure
    base = rd_n;
    UartDataOut = 8'h33;
    UartDataReady = 1'b1;
    idle(40);
    check("rxfill_reads", rd_n - base, 16);
    apb_read(6'h08, rd);
    check("rxfull_fstat", rd, 32'h0009_1000);
    base = rd_n;
    apb_read(6'h04, rd);
    check("rxfull_pop", rd, 32'h0000_0133);
    idle(10);
    check("rxfull_one_more", rd_n - base, 1);
    apb_read(6'h08, rd);
    check("rxfull_again", rd, 32'h0009_1000);
    UartDataReady = 1'b0;

    // RX IRQ
    apb_write(6'h08, 32'h2000_0000);
    apb_write(6'h08, 32'h0100_0000);
    idle(2);
    check("irq_off_empty", {31'h0, IRQ}, 32'h0);
    UartDataOut = 8'h77;
    UartDataReady = 1'b1;
    @(posedge PCLK); #1;
    UartDataReady = 1'b0;
    @(negedge PCLK);
    check("irq_latency0", {31'h0, IRQ}, 32'h0);
    @(negedge PCLK);
    check("irq_latency1", {31'h0, IRQ}, 32'h1);
    apb_write(6'h08, 32'h2100_0000);
    @(negedge PCLK);
    check("irq_flush_hold", {31'h0, IRQ}, 32'h1);
    @(negedge PCLK);
    check("irq_flush_fall", {31'h0, IRQ}, 32'h0);
    apb_read(6'h08, rd);
    check("rx_flush_fstat", rd, 32'h0105_0000);

    // TX IRQ
    apb_write(6'h08, 32'h0200_0000);
    idle(2);
    check("tx_irq", {31'h0, IRQ}, 32'h1);
    apb_write(6'h08, 32'h0000_0000);
    idle(2);
    check("irq_disabled", {31'h0, IRQ}, 32'h0);

    // Undecoded address
    apb_write(6'h10, 32'h0000_00FF);
    apb_read(6'h10, rd);
    check("undecoded_read", rd, 32'h0);
    apb_read(6'h08, rd);
    check("undecoded_write", rd, 32'h0005_0000);

    // Reset during TX_HOLD
    UartTHEmpty = 1'b1;
    apb_write(6'h00, 32'h99);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge PCLK);
      if (UartWrite) found = 1'b1;
    end
    check("hold_seen", {31'h0, found}, 32'h1);
    check("hold_data", {24'h0, UartDataIn}, 32'h99);
    PRST_N = 1'b0;
    #1;
    check("rst_mid_write", {31'h0, UartWrite}, 32'h0);
    check("rst_mid_datain", {24'h0, UartDataIn}, 32'h0);
    UartTHEmpty = 1'b0;
    idle(2);
    PRST_N = 1'b1;
    apb_read(6'h08, rd);
    check("rst_mid_fstat", rd, 32'h0005_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
